// File: rtl/div_fu.sv
// rtl/div_fu.sv - iterative restoring integer divide functional unit (UDIV/SDIV)
//
// Purpose: accepts one A64 UDIV/SDIV from the issue queue while idle, runs a
// restoring shift-subtract divide producing STEPS_PER_CYCLE quotient bits per
// clock, and holds the quotient on the result broadcast until granted.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   fu_ready         unit idle, an instruction may be accepted this cycle
//   inst_valid       issue queue presents an instruction
//   inst_id, inst    instruction ID and encoding (inst[31]=sf, inst[10]=signed)
//   op[]             operand values, op[0]=dividend, op[1]=divisor
//   out_prn[]        destination PRNs, only out_prn[0] is used
//   pc               program counter (not needed by the divide)
//   result_valid     broadcast holds a completed result
//   result_ready     broadcast grant
//   result_inst_id   ID of the completed instruction
//   result_prn       destination PRN
//   result_value     quotient, zero-extended to 64 bits
module div_fu #(
  parameter int INST_ID_BITS    = 6,
  parameter int PRN_BITS        = 6,
  parameter int MAX_OPERANDS    = 3,
  parameter int STEPS_PER_CYCLE = 1  // 1, 2, 4 or 8
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    fu_ready,
  input  logic                    inst_valid,
  input  logic [INST_ID_BITS-1:0] inst_id,
  input  logic [31:0]             inst,
  input  logic [63:0]             op [MAX_OPERANDS],
  input  logic [PRN_BITS-1:0]     out_prn [MAX_OPERANDS],
  input  logic [63:0]             pc,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [INST_ID_BITS-1:0] result_inst_id,
  output logic [PRN_BITS-1:0]     result_prn,
  output logic [63:0]             result_value
);

  typedef enum logic [2:0] {IDLE, PREP, DIV, FIX, DONE} state_e;

  state_e                  state_q, state_d;
  logic                    is64_q, is64_d;
  logic                    sdiv_q, sdiv_d;
  logic                    neg_q, neg_d;
  logic [63:0]             dvd_q, dvd_d;   // raw dividend as issued
  logic [63:0]             dvs_q, dvs_d;   // raw divisor as issued
  logic [63:0]             div_q, div_d;   // divisor magnitude
  logic [63:0]             quo_q, quo_d;   // dividend shifts out of the top, quotient in at the bottom
  logic [64:0]             rem_q, rem_d;   // one extra bit so the shifted remainder never overflows
  logic [6:0]              cnt_q, cnt_d;
  logic [INST_ID_BITS-1:0] id_q, id_d;
  logic [PRN_BITS-1:0]     prn_q, prn_d;
  logic                    result_valid_q, result_valid_d;
  logic [INST_ID_BITS-1:0] result_inst_id_q, result_inst_id_d;
  logic [PRN_BITS-1:0]     result_prn_q, result_prn_d;
  logic [63:0]             result_value_q, result_value_d;

  logic        a_n, b_n;
  logic [31:0] a_lo, b_lo;
  logic [63:0] a_m, b_m, q, qf;
  logic [64:0] r;
  logic [6:0]  last_cnt;
  logic        unused_fold;

  // Fold inputs the divide never looks at, keeping them visibly consumed.
  always_comb begin
    unused_fold = ^{pc, inst[30:11], inst[9:0]};
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      unused_fold = unused_fold ^ (^op[i]) ^ (^out_prn[i]);
    end
  end

  always_comb begin
    state_d          = state_q;
    is64_d           = is64_q;
    sdiv_d           = sdiv_q;
    neg_d            = neg_q;
    dvd_d            = dvd_q;
    dvs_d            = dvs_q;
    div_d            = div_q;
    quo_d            = quo_q;
    rem_d            = rem_q;
    cnt_d            = cnt_q;
    id_d             = id_q;
    prn_d            = prn_q;
    result_valid_d   = result_valid_q;
    result_inst_id_d = result_inst_id_q;
    result_prn_d     = result_prn_q;
    result_value_d   = result_value_q;
    a_lo     = dvd_q[31:0];
    b_lo     = dvs_q[31:0];
    a_n      = 1'b0;
    b_n      = 1'b0;
    a_m      = '0;
    b_m      = '0;
    q        = quo_q;
    r        = rem_q;
    qf       = '0;
    last_cnt = is64_q ? 7'(64 / STEPS_PER_CYCLE - 1) : 7'(32 / STEPS_PER_CYCLE - 1);

    case (state_q)
      IDLE: begin
        if (inst_valid) begin
          is64_d  = inst[31];
          sdiv_d  = inst[10];
          dvd_d   = op[0];
          dvs_d   = op[1];
          id_d    = inst_id;
          prn_d   = out_prn[0];
          state_d = PREP;
        end
      end
      PREP: begin
        if (is64_q) begin
          a_n = sdiv_q & dvd_q[63];
          b_n = sdiv_q & dvs_q[63];
          a_m = a_n ? (~dvd_q + 64'd1) : dvd_q;
          b_m = b_n ? (~dvs_q + 64'd1) : dvs_q;
        end else begin
          a_n = sdiv_q & a_lo[31];
          b_n = sdiv_q & b_lo[31];
          // 32-bit dividend is left-aligned so the MSB-first loop is width independent.
          a_m = {(a_n ? (~a_lo + 32'd1) : a_lo), 32'd0};
          b_m = {32'd0, (b_n ? (~b_lo + 32'd1) : b_lo)};
        end
        div_d = b_m;
        rem_d = '0;
        cnt_d = '0;
        if (b_m == 64'd0) begin
          // Zero divisor skips the iteration; FIX then publishes a zero quotient.
          quo_d   = '0;
          neg_d   = 1'b0;
          state_d = FIX;
        end else begin
          quo_d   = a_m;
          neg_d   = a_n ^ b_n;
          state_d = DIV;
        end
      end
      DIV: begin
        for (int s = 0; s < STEPS_PER_CYCLE; s++) begin
          r = {r[63:0], q[63]};
          q = {q[62:0], 1'b0};
          if (r >= {1'b0, div_q}) begin
            r    = r - {1'b0, div_q};
            q[0] = 1'b1;
          end
        end
        rem_d = r;
        quo_d = q;
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == last_cnt) state_d = FIX;
      end
      FIX: begin
        qf               = neg_q ? (~quo_q + 64'd1) : quo_q;
        result_value_d   = is64_q ? qf : {32'd0, qf[31:0]};
        result_inst_id_d = id_q;
        result_prn_d     = prn_q;
        result_valid_d   = 1'b1;
        state_d          = DONE;
      end
      DONE: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      is64_q           <= 1'b0;
      sdiv_q           <= 1'b0;
      neg_q            <= 1'b0;
      dvd_q            <= '0;
      dvs_q            <= '0;
      div_q            <= '0;
      quo_q            <= '0;
      rem_q            <= '0;
      cnt_q            <= '0;
      id_q             <= '0;
      prn_q            <= '0;
      result_valid_q   <= 1'b0;
      result_inst_id_q <= '0;
      result_prn_q     <= '0;
      result_value_q   <= '0;
    end else begin
      state_q          <= state_d;
      is64_q           <= is64_d;
      sdiv_q           <= sdiv_d;
      neg_q            <= neg_d;
      dvd_q            <= dvd_d;
      dvs_q            <= dvs_d;
      div_q            <= div_d;
      quo_q            <= quo_d;
      rem_q            <= rem_d;
      cnt_q            <= cnt_d;
      id_q             <= id_d;
      prn_q            <= prn_d;
      result_valid_q   <= result_valid_d;
      result_inst_id_q <= result_inst_id_d;
      result_prn_q     <= result_prn_d;
      result_value_q   <= result_value_d;
    end
  end

  assign fu_ready       = (state_q == IDLE);
  assign result_valid   = result_valid_q;
  assign result_inst_id = result_inst_id_q;
  assign result_prn     = result_prn_q;
  assign result_value   = result_value_q;

endmodule

// File: tb/tb_div_fu.sv
// tb/tb_div_fu.sv - self-checking bench for div_fu (STEPS_PER_CYCLE 1 and 4 instances)
module tb_div_fu;

  localparam logic [31:0] UDIV64 = 32'h9AC10820;
  localparam logic [31:0] SDIV64 = 32'h9AC10C20;
  localparam logic [31:0] UDIV32 = 32'h1AC10820;
  localparam logic [31:0] SDIV32 = 32'h1AC10C20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [5:0]  inst_id;
  logic [31:0] inst;
  logic [63:0] op [3];
  logic [5:0]  out_prn [3];
  logic [63:0] pc;
  logic        iv1, iv4, rr1, rr4;
  logic        fr1, fr4, rv1, rv4;
  logic [5:0]  rid1, rid4, rp1, rp4;
  logic [63:0] val1, val4;

  div_fu #(.STEPS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .fu_ready(fr1), .inst_valid(iv1), .inst_id(inst_id),
    .inst(inst), .op(op), .out_prn(out_prn), .pc(pc), .result_valid(rv1),
    .result_ready(rr1), .result_inst_id(rid1), .result_prn(rp1), .result_value(val1));

  div_fu #(.STEPS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .fu_ready(fr4), .inst_valid(iv4), .inst_id(inst_id),
    .inst(inst), .op(op), .out_prn(out_prn), .pc(pc), .result_valid(rv4),
    .result_ready(rr4), .result_inst_id(rid4), .result_prn(rp4), .result_value(val4));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic g_fr(input bit s4); return s4 ? fr4 : fr1; endfunction
  function automatic logic g_rv(input bit s4); return s4 ? rv4 : rv1; endfunction
  function automatic logic [63:0] g_val(input bit s4); return s4 ? val4 : val1; endfunction
  function automatic logic [5:0] g_id(input bit s4); return s4 ? rid4 : rid1; endfunction
  function automatic logic [5:0] g_prn(input bit s4); return s4 ? rp4 : rp1; endfunction

  task automatic set_iv(input bit s4, input logic v);
    if (s4) iv4 = v; else iv1 = v;
  endtask
  task automatic set_rr(input bit s4, input logic v);
    if (s4) rr4 = v; else rr1 = v;
  endtask

  // Architectural reference: plain integer division, truncating toward zero.
  function automatic logic [63:0] model(input logic [31:0] ins, input logic [63:0] a,
                                        input logic [63:0] b);
    logic [63:0] ua, ub, q;
    longint sa, sb;
    if (ins[31]) begin ua = a; ub = b; end
    else begin ua = {32'd0, a[31:0]}; ub = {32'd0, b[31:0]}; end
    if (ub == 64'd0) return 64'd0;
    if (!ins[10]) begin
      q = ua / ub;
    end else if (ins[31]) begin
      sa = a;
      sb = b;
      if (a == 64'h8000_0000_0000_0000 && sb == -64'sd1) q = a;
      else q = sa / sb;
    end else begin
      sa = $signed(a[31:0]);
      sb = $signed(b[31:0]);
      q = sa / sb;
      q = {32'd0, q[31:0]};
    end
    return q;
  endfunction

  function automatic int model_lat(input logic [31:0] ins, input logic [63:0] b, input int steps);
    logic [63:0] ub;
    ub = ins[31] ? b : {32'd0, b[31:0]};
    if (ub == 64'd0) return 2;
    return (ins[31] ? 64 : 32) / steps + 2;
  endfunction

  task automatic do_op(input bit s4, input logic [31:0] ins, input logic [63:0] a,
                       input logic [63:0] b, input logic [5:0] id, input logic [5:0] prn,
                       input int hold, input bit early, input string tag);
    int n;
    logic [63:0] v;
    logic [63:0] exp;
    int exp_lat;
    exp     = model(ins, a, b);
    exp_lat = model_lat(ins, b, s4 ? 4 : 1);
    n = 0;
    while (!g_fr(s4) && n < 300) begin @(posedge clk); #1; n++; end
    check({tag, " idle"}, 64'(g_fr(s4)), 64'd1);
    inst = ins; op[0] = a; op[1] = b; op[2] = {$urandom, $urandom};
    inst_id = id; out_prn[0] = prn; out_prn[1] = ~prn; pc = {$urandom, $urandom};
    set_iv(s4, 1'b1);
    set_rr(s4, early);
    @(posedge clk); #1;
    set_iv(s4, 1'b0);
    // Scramble the buses: the unit must work from its latched copy.
    inst = $urandom; op[0] = {$urandom, $urandom}; op[1] = {$urandom, $urandom};
    inst_id = 6'($urandom); out_prn[0] = 6'($urandom);
    n = 0;
    while (!g_rv(s4) && n < 300) begin @(posedge clk); #1; n++; end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " value"}, g_val(s4), exp);
    check({tag, " inst_id"}, 64'(g_id(s4)), 64'(id));
    check({tag, " prn"}, 64'(g_prn(s4)), 64'(prn));
    check({tag, " busy"}, 64'(g_fr(s4)), 64'd0);
    v = g_val(s4);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold valid"}, 64'(g_rv(s4)), 64'd1);
      check({tag, " hold value"}, g_val(s4), v);
      check({tag, " hold busy"}, 64'(g_fr(s4)), 64'd0);
    end
    set_rr(s4, 1'b1);
    @(posedge clk); #1;
    set_rr(s4, 1'b0);
    check({tag, " granted valid"}, 64'(g_rv(s4)), 64'd0);
    check({tag, " granted ready"}, 64'(g_fr(s4)), 64'd1);
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [11];
  logic [31:0] kinds [4];
  int n;
  bit seen;

  initial begin
    vecs[0]  = '{UDIV64, 64'd100, 64'd7, 64'd14};
    vecs[1]  = '{SDIV64, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[2]  = '{SDIV64, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[3]  = '{SDIV64, -64'sd7, -64'sd2, 64'd3};
    vecs[4]  = '{UDIV64, 64'h1234, 64'd0, 64'd0};
    vecs[5]  = '{SDIV32, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0000_0000_8000_0000};
    vecs[6]  = '{UDIV32, 64'hFFFF_FFFF_0000_0064, 64'd5, 64'd20};
    vecs[7]  = '{SDIV64, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    vecs[8]  = '{UDIV64, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[9]  = '{SDIV32, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'h0000_0000_FFFF_FFFD};
    vecs[10] = '{UDIV32, 64'd5, 64'h0000_0001_0000_0000, 64'd0};
    kinds[0] = UDIV64; kinds[1] = SDIV64; kinds[2] = UDIV32; kinds[3] = SDIV32;

    rst = 1'b1; iv1 = 0; iv4 = 0; rr1 = 0; rr4 = 0;
    inst = '0; inst_id = '0; pc = '0;
    for (int i = 0; i < 3; i++) begin op[i] = '0; out_prn[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    check("reset fu_ready", 64'(fr1), 64'd1);
    check("reset result_valid", 64'(rv1), 64'd0);
    check("reset value", val1, 64'd0);
    check("reset id/prn", 64'({rid1, rp1}), 64'd0);
    check("reset s4 fu_ready/valid", 64'({fr4, rv4}), 64'b10);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table: constant expectations, each vector on both step widths.
    for (int i = 0; i < 11; i++) begin
      check($sformatf("vec%0d model", i), model(vecs[i].ins, vecs[i].a, vecs[i].b), vecs[i].exp);
      do_op(1'b0, vecs[i].ins, vecs[i].a, vecs[i].b, 6'(i + 1), 6'(40 + i), 0, 1'b0,
            $sformatf("vec%0d s1", i));
      do_op(1'b1, vecs[i].ins, vecs[i].a, vecs[i].b, 6'(i + 20), 6'(50 - i), 0, 1'b0,
            $sformatf("vec%0d s4", i));
    end

    // Withheld grant for 10 cycles, then a back-to-back second op.
    do_op(1'b0, UDIV64, 64'd1000, 64'd3, 6'd33, 6'd34, 10, 1'b0, "hold");
    do_op(1'b0, SDIV64, -64'sd1000, 64'd7, 6'd35, 6'd36, 0, 1'b0, "back2back");

    // inst_valid while busy is ignored.
    inst = UDIV64; op[0] = 64'd1000; op[1] = 64'd10; inst_id = 6'd7; out_prn[0] = 6'd9;
    iv1 = 1'b1;
    @(posedge clk); #1;
    inst = SDIV64; op[0] = -64'sd50; op[1] = 64'd3; inst_id = 6'd8; out_prn[0] = 6'd1;
    repeat (5) begin @(posedge clk); #1; end
    iv1 = 1'b0;
    n = 0;
    while (!rv1 && n < 300) begin @(posedge clk); #1; n++; end
    check("busy-ignore value", val1, 64'd100);
    check("busy-ignore id/prn", 64'({rid1, rp1}), 64'({6'd7, 6'd9}));
    rr1 = 1'b1; @(posedge clk); #1; rr1 = 1'b0;

    // Asynchronous reset in the middle of the divide.
    inst = UDIV64; op[0] = 64'd100; op[1] = 64'd7; inst_id = 6'd3; out_prn[0] = 6'd4;
    iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("pre-reset busy", 64'(fr1), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("async reset fu_ready", 64'(fr1), 64'd1);
    check("async reset valid", 64'(rv1), 64'd0);
    check("async reset value", val1, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (rv1) seen = 1'b1; end
    check("dropped op no broadcast", 64'(seen), 64'd0);
    do_op(1'b0, UDIV64, 64'd100, 64'd7, 6'd5, 6'd6, 0, 1'b0, "after reset");
    do_op(1'b1, SDIV32, 64'h8000_0000, 64'hFFFF_FFFF, 6'd11, 6'd12, 0, 1'b0, "after reset s4");

    // Randomized ops checked against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [63:0] a, b;
      logic [31:0] k;
      bit early;
      k = kinds[$urandom_range(0, 3)];
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, 300));
      case ($urandom_range(0, 3))
        0: b = 64'($urandom_range(0, 7));
        1: b = {$urandom, $urandom};
        2: b = {$urandom, 32'($urandom_range(0, 9))};
        default: b = -64'($urandom_range(1, 5));
      endcase
      early = 1'($urandom_range(0, 1));
      do_op(1'(i % 2), k, a, b, 6'($urandom), 6'($urandom), early ? 0 : $urandom_range(0, 2),
            early, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
